// File: rtl/seq_run_controller.sv
// Run controller: shifts a latched N-bit pattern MSB-first to the sequence detector, counts its hits and gives a verdict.
// Optional build macro SEQ_CTRL_LOOP_EN adds a loop input that re-runs the latched pattern back to back.
module seq_run_controller #(
    parameter int N     = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
`ifdef SEQ_CTRL_LOOP_EN
    input  logic             loop,
`endif
    input  logic [N-1:0]     pattern_in,
    input  logic [CNT_W-1:0] exp_0110,
    input  logic [CNT_W-1:0] exp_1001,
    input  logic             hit_0110,
    input  logic             hit_1001,
    output logic             bit_out,
    output logic             det_clr,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] cnt_0110,
    output logic [CNT_W-1:0] cnt_1001
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pat_q, pat_d;
    logic [CNT_W-1:0] exp0_q, exp0_d, exp1_q, exp1_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drain_q, drain_d;
    logic             bit_q, bit_d;
    logic             pass_q, pass_d;
    logic             sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            exp0_q  <= '0;
            exp1_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            idx_q   <= '0;
            drain_q <= 1'b0;
            bit_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            exp0_q  <= exp0_d;
            exp1_q  <= exp1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            bit_q   <= bit_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        exp0_d  = exp0_q;
        exp1_d  = exp1_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        bit_d   = bit_q;
        pass_d  = pass_q;
        det_clr = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        sample  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern_in;
                    exp0_d  = exp_0110;
                    exp1_d  = exp_1001;
                    cnt0_d  = '0;
                    cnt1_d  = '0;
                    pass_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                det_clr = 1'b1;
                busy    = 1'b1;
                idx_d   = IDX_W'(N - 1);
                state_d = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                sample = tick;
                if (tick) begin
                    bit_d = pat_q[idx_q];
                    if (idx_q == '0) begin
                        drain_d = 1'b0;
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            // Two extra ticks flush the last bits through bit_out and the detector register.
            S_DRAIN: begin
                busy   = 1'b1;
                sample = tick;
                if (tick) begin
                    if (drain_q) state_d = S_CHECK;
                    else         drain_d = 1'b1;
                end
            end
            S_CHECK: begin
                busy    = 1'b1;
                pass_d  = (cnt0_q == exp0_q) && (cnt1_q == exp1_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
`ifdef SEQ_CTRL_LOOP_EN
                if (loop) begin
                    cnt0_d  = '0;
                    cnt1_d  = '0;
                    pass_d  = 1'b0;
                    state_d = S_LOAD;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (sample && hit_0110 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (sample && hit_1001 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
    end

    assign bit_out  = bit_q;
    assign pass     = pass_q;
    assign cnt_0110 = cnt0_q;
    assign cnt_1001 = cnt1_q;

endmodule

// File: doc/seq_run_controller.md
Name: seq_run_controller

Overview:
Run controller for the serial pattern/detector datapath. It latches an N-bit pattern on a start request and shifts it out MSB-first, one bit per tick strobe, to the dual Moore sequence detector. It counts the detector's 0110 and 1001 hit flags and compares the counts with expected values to give a pass/fail verdict. It sits between the clock-divider tick and the detector, replacing the free-running generator in the self-test top.

Parameters:
N, 16, pattern length in bits (N >= 2)
CNT_W, 5, hit counter width; counters saturate at 2^CNT_W-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk strobe; the bit/detector step rate
start  input  1  run request; honoured only in IDLE
pattern_in  input  N  pattern; latched in the start cycle
exp_0110  input  CNT_W  expected 0110 hit count; latched with the pattern
exp_1001  input  CNT_W  expected 1001 hit count; latched with the pattern
hit_0110  input  1  detector 0110 flag (level, one detector step wide)
hit_1001  input  1  detector 1001 flag
bit_out  output  1  serial bit to the detector
det_clr  output  1  one-clk synchronous clear pulse to the detector
busy  output  1  high from LOAD through CHECK
done  output  1  one-clk pulse when the verdict is valid
pass  output  1  verdict; held until the next accepted start
cnt_0110  output  CNT_W  0110 hit count of the current/last run
cnt_1001  output  CNT_W  1001 hit count of the current/last run

Behaviour:
- Reset is asynchronous, active-high, clock clk. All outputs and counters go to 0, state goes to IDLE, the pattern register clears.
- States are IDLE, LOAD, RUN, DRAIN, CHECK, DONE.
- IDLE: if start=1, latch pattern_in, exp_0110 and exp_1001; clear cnt_0110, cnt_1001 and pass; go to LOAD. A tick in the same cycle is ignored.
- LOAD: lasts exactly one clk. det_clr=1, bit index=N-1, busy=1. Next state is RUN.
- RUN: on each tick, bit_out <= pattern[idx]. If idx==0, go to DRAIN with drain count 0; otherwise idx decrements. bit_out holds between ticks.
- DRAIN: lasts 2 ticks so the last two bits propagate through the registered bit_out and the detector state register. bit_out holds the last bit.
- Hit sampling: only on tick cycles in RUN or DRAIN. If hit_x=1, cnt_x increments. Hits on non-tick cycles or in other states are never counted.
- Saturation: a counter at 2^CNT_W-1 stays there.
- Simultaneous hits: both counters may increment in the same tick.
- CHECK: lasts one clk. pass <= (cnt_0110==exp_0110) && (cnt_1001==exp_1001). Next state is DONE.
- DONE: lasts one clk. done=1, busy=0. Next state is IDLE. cnt_* and pass hold.
- Latency: a run occupies 1 (LOAD) + N ticks + 2 ticks + 2 clk. First bit appears on the first tick after LOAD.
- A start while busy is ignored, with no effect on the latched data.
- Reset mid-run aborts immediately to the reset values. No done pulse is issued.

Optional Feature:
SEQ_CTRL_LOOP_EN:
- Defined: adds input port loop (1 bit). In DONE, if loop=1, go to LOAD instead of IDLE and reuse the latched pattern and expectations.
  - Counters and pass clear on re-entry to LOAD.
  - done still pulses every run.
  - While looping, start is ignored.
- Undefined: no loop port exists; DONE always returns to IDLE.

Test Plan:
1. Reset, then hold: all outputs 0 and state IDLE; after release, busy stays 0 with no start.
2. Defaults; start with pattern 16'hA5C3, exp 0/0, tick every 4 clk, hits held 0 -> det_clr pulses once; bit_out is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on successive ticks; done pulses 18 ticks + 2 clk after LOAD; pass=1.
3. Same run with hit_0110 high on ticks 5, 9 and 14 and hit_1001 high on ticks 3 and 17 (tick 17 is in DRAIN) -> cnt_0110=3, cnt_1001=2. With exp 3/2, pass=1; with exp 3/1, pass=0.
4. Hit flags high on non-tick cycles and during LOAD/CHECK -> counts unchanged (0/0).
5. Reset asserted at tick 7 of RUN -> same cycle: busy=0, bit_out=0, counts 0, no done. A new start replays from bit 15.
6. CNT_W=2 with 5 hit_0110 ticks -> cnt_0110=3. A start pulsed at RUN tick 4 is ignored. With SEQ_CTRL_LOOP_EN and loop=1, two back-to-back runs each give one done pulse.
